sdcard_dma_reader: RTL
======================

SDCARD_DMA_READER -- requirements
Module: sdcard_dma_reader

Interface
REQ-001 SHALL provide parameter MAX_BURST, default 16, maximum beats (32-bit words) per burst.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1024, idle cycles tolerated while waiting for ack or data.
REQ-003 SHALL provide parameter CACHE_ATTR, default 4'hF, value driven on dma_cache_o during requests.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 PCLK_i  input  1  APB clock.
REQ-006 PRESETn_i  input  1  asynchronous reset, active low.
REQ-007 dma_req_o  output  1  burst read request.
REQ-008 dma_ack_i  input  1  request accepted.
REQ-009 dma_addr_o  output  32  burst start byte address.
REQ-010 dma_len_o  output  16  burst length in words.
REQ-011 dma_we_o  output  1  constant 0 (memory read).
REQ-012 dma_burst_o  output  1  high when dma_len_o > 1.
REQ-013 dma_cache_o  output  4  cache attributes.
REQ-014 dma_rdata_i  input  32  read data beat.
REQ-015 dma_rvalid_i  input  1  read data valid.
REQ-016 rd_start  input  1  single-cycle start pulse.
REQ-017 rd_base_addr / rd_length  input  32 / 16  base address, length in words.
REQ-018 rd_busy, rd_done, rd_error  output  1 each  status; done and error are one-cycle pulses.
REQ-019 fifo_wdata  output  32, fifo_write  output  1, fifo_full  input  1, fifo_space  input  8 (free words).
REQ-020 security_lock, access_granted  input  1 each  access control.

Function
REQ-021 FSM states SHALL be IDLE, REQUEST, DATA, COMPLETE, ERROR.
REQ-022 IDLE: on rd_start, latch base and length; security_lock=1, access_granted=0 or rd_base_addr[1:0]!=0 -> ERROR; rd_length=0 -> COMPLETE; else -> REQUEST.
REQ-023 rd_start while not IDLE SHALL be ignored.
REQ-024 REQUEST: burst length = min(remaining, MAX_BURST); dma_req_o asserts only when fifo_space >= burst length, with addr/len/cache stable, held until dma_ack_i sampled high.
REQ-025 Cycle dma_req_o & dma_ack_i SHALL deassert dma_req_o next cycle and enter DATA.
REQ-026 DATA: each dma_rvalid_i beat SHALL produce fifo_write=1 with fifo_wdata=dma_rdata_i exactly one cycle later; address +4, remaining -1.
REQ-027 After the last beat of a burst: remaining=0 -> COMPLETE, else -> REQUEST with updated address.
REQ-028 dma_rvalid_i while not in DATA SHALL be ignored; dma_rvalid_i while fifo_full=1 -> ERROR, beat dropped.
REQ-029 Address arithmetic SHALL wrap modulo 2^32; no 4 KB boundary splitting.
REQ-030 Watchdog counts cycles in REQUEST with dma_req_o high and in DATA without rvalid; reaching TIMEOUT_CYCLES -> ERROR; cleared on ack, rvalid, or state change.
REQ-031 security_lock rising or access_granted falling in REQUEST/DATA SHALL abort -> ERROR, dropping dma_req_o next cycle.
REQ-032 COMPLETE: rd_done=1 one cycle -> IDLE; ERROR: rd_error=1 one cycle -> IDLE; done and error never both high.
REQ-033 rd_busy SHALL be high in REQUEST and DATA only.

Reset
REQ-034 Reset SHALL force IDLE, all outputs 0 (dma_cache_o 4'h0), clear counters and watchdog, asynchronously.
REQ-035 Reset mid-burst SHALL drop dma_req_o and fifo_write immediately, with no done or error pulse.

Structure
REQ-036 State typedef, MAX_BURST and TIMEOUT_CYCLES defaults SHALL live in shared package sdcard_dma_pkg.
REQ-037 Watchdog SHALL be sub-module sdcard_dma_watchdog (count, clear, expire); rest is flat.

Verification
REQ-038 base 0x1000, length 40, immediate ack, rvalid every cycle -> bursts 16/16/8 at 0x1000/0x1040/0x1080, 40 fifo_writes in order, one rd_done.
REQ-039 length 4, fifo_space=2 for 20 cycles then 16 -> dma_req_o low until space >= 4, then single burst len 4.
REQ-040 base 0xFFFFFFF8, length 4 -> addresses wrap, second word at 0xFFFFFFFC, next increment 0x00000000; done pulse.
REQ-041 dma_ack_i never asserted -> rd_error at TIMEOUT_CYCLES after request, dma_req_o low afterwards.
REQ-042 fifo_full=1 during beat 3 -> rd_error, no further fifo_write; security_lock raised mid-DATA -> rd_error next cycle.
REQ-043 PRESETn_i low during DATA beat 5 -> all outputs 0 same cycle; fresh rd_start runs normally.

Source files
------------

// File: rtl/sdcard_dma_pkg.sv
// Shared types and defaults for the SD-card DMA read engine.
package sdcard_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQUEST  = 3'd1,
    ST_DATA     = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  localparam int DEF_MAX_BURST      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Words to ask for in the next burst: whatever is left, capped at the burst limit.
  function automatic logic [15:0] burst_len(input logic [15:0] remaining,
                                            input logic [15:0] max_burst);
    return (remaining > max_burst) ? max_burst : remaining;
  endfunction

endpackage

// File: rtl/sdcard_dma_watchdog.sv
// Idle-cycle watchdog: counts qualified cycles, flags the cycle that reaches the limit.
module sdcard_dma_watchdog
  import sdcard_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic PCLK_i,
  input  logic PRESETn_i,
  input  logic count,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  // Expiry depends only on the stored count and the count qualifier, never on
  // clear, so the parent may derive clear from its next-state logic.
  assign expire = count && (cnt_reg == LIMIT);

  // Cycle counter: clear wins, otherwise advance on every qualified cycle.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (count) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/sdcard_dma_reader.sv
// Reads rd_length words from memory in bursts and streams them into a FIFO.
module sdcard_dma_reader
  import sdcard_dma_pkg::*;
#(
  parameter int         MAX_BURST      = DEF_MAX_BURST,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [3:0] CACHE_ATTR     = 4'hF
) (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  output logic        dma_req_o,
  input  logic        dma_ack_i,
  output logic [31:0] dma_addr_o,
  output logic [15:0] dma_len_o,
  output logic        dma_we_o,
  output logic        dma_burst_o,
  output logic [3:0]  dma_cache_o,
  input  logic [31:0] dma_rdata_i,
  input  logic        dma_rvalid_i,
  input  logic        rd_start,
  input  logic [31:0] rd_base_addr,
  input  logic [15:0] rd_length,
  output logic        rd_busy,
  output logic        rd_done,
  output logic        rd_error,
  output logic [31:0] fifo_wdata,
  output logic        fifo_write,
  input  logic        fifo_full,
  input  logic [7:0]  fifo_space,
  input  logic        security_lock,
  input  logic        access_granted
);

  localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [15:0] rem_reg, rem_next;
  logic [15:0] beats_reg, beats_next;
  logic [15:0] blen_reg, blen_next;
  logic        req_reg, req_next;
  logic        fw_reg, fw_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        lock_q_reg, grant_q_reg;

  logic [15:0] blen_calc;
  logic        busy_state;
  logic        abort;
  logic        wd_count, wd_clear, wd_expire;

  assign busy_state = (state_reg == ST_REQUEST) || (state_reg == ST_DATA);
  assign blen_calc  = burst_len(rem_reg, MAX_BURST_W);
  // Access revoked while a transfer is running: lock just rose or grant just fell.
  assign abort = busy_state &&
                 ((security_lock && !lock_q_reg) || (!access_granted && grant_q_reg));

  // Watchdog runs while a request waits for ack, or while DATA waits for a beat.
  assign wd_count = ((state_reg == ST_REQUEST) && req_reg && !dma_ack_i) ||
                    ((state_reg == ST_DATA) && !dma_rvalid_i);
  assign wd_clear = (state_next != state_reg) || dma_ack_i || dma_rvalid_i;

  sdcard_dma_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .PCLK_i   (PCLK_i),
    .PRESETn_i(PRESETn_i),
    .count    (wd_count),
    .clear    (wd_clear),
    .expire   (wd_expire)
  );

  // Registered state, datapath and edge-detect history.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      rem_reg     <= '0;
      beats_reg   <= '0;
      blen_reg    <= '0;
      req_reg     <= 1'b0;
      fw_reg      <= 1'b0;
      wdata_reg   <= '0;
      lock_q_reg  <= 1'b0;
      grant_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      rem_reg     <= rem_next;
      beats_reg   <= beats_next;
      blen_reg    <= blen_next;
      req_reg     <= req_next;
      fw_reg      <= fw_next;
      wdata_reg   <= wdata_next;
      lock_q_reg  <= security_lock;
      grant_q_reg <= access_granted;
    end
  end

  // Next-state and datapath updates for the transfer sequencer.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    beats_next = beats_reg;
    blen_next  = blen_reg;
    req_next   = req_reg;
    fw_next    = 1'b0;
    wdata_next = wdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (rd_start) begin
          addr_next = rd_base_addr;
          rem_next  = rd_length;
          if (security_lock || !access_granted || (rd_base_addr[1:0] != 2'b00)) begin
            state_next = ST_ERROR;
          end else if (rd_length == 16'd0) begin
            state_next = ST_COMPLETE;
          end else begin
            state_next = ST_REQUEST;
          end
        end
      end

      ST_REQUEST: begin
        if (abort || wd_expire) begin
          state_next = ST_ERROR;
        end else if (req_reg) begin
          if (dma_ack_i) begin
            req_next   = 1'b0;
            beats_next = blen_reg;
            state_next = ST_DATA;
          end
        end else if ({8'h00, fifo_space} >= blen_calc) begin
          // Only ask once the FIFO can swallow the whole burst; length is frozen here.
          req_next  = 1'b1;
          blen_next = blen_calc;
        end
      end

      ST_DATA: begin
        if (abort || wd_expire) begin
          state_next = ST_ERROR;
        end else if (dma_rvalid_i) begin
          if (fifo_full) begin
            // Beat is dropped; the transfer cannot be completed coherently.
            state_next = ST_ERROR;
          end else begin
            fw_next    = 1'b1;
            wdata_next = dma_rdata_i;
            addr_next  = addr_reg + 32'd4;
            rem_next   = rem_reg - 16'd1;
            beats_next = beats_reg - 16'd1;
            if (beats_reg == 16'd1) begin
              state_next = (rem_reg == 16'd1) ? ST_COMPLETE : ST_REQUEST;
            end
          end
        end
      end

      ST_COMPLETE: state_next = ST_IDLE;
      ST_ERROR:    state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase

    // A request never outlives the REQUEST state (covers abort and timeout).
    if (state_next != ST_REQUEST) begin
      req_next = 1'b0;
    end
  end

  assign dma_req_o   = req_reg;
  assign dma_addr_o  = addr_reg;
  assign dma_len_o   = blen_reg;
  assign dma_we_o    = 1'b0;
  assign dma_burst_o = (blen_reg > 16'd1);
  assign dma_cache_o = req_reg ? CACHE_ATTR : 4'h0;
  assign fifo_write  = fw_reg;
  assign fifo_wdata  = wdata_reg;
  assign rd_busy     = busy_state;
  assign rd_done     = (state_reg == ST_COMPLETE);
  assign rd_error    = (state_reg == ST_ERROR);

endmodule
